// File: rtl/led_pulse_stretcher_pkg.sv
// Shared types and helpers for the LED pulse stretcher.
// Holds the FSM state encoding and the timer width calculation.
package led_pulse_stretcher_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Timer must reach max(on, gap) - 1 and is never narrower than one bit.
    function automatic int timer_width(input int on_cycles, input int gap_cycles);
        int longest;
        int width;
        longest = (on_cycles > gap_cycles) ? on_cycles : gap_cycles;
        width   = $clog2(longest);
        return (width < 1) ? 1 : width;
    endfunction

endpackage

// File: rtl/led_pulse_stretcher_rise_detect.sv
// Registered rising-edge detector: one event per low-to-high transition of d.
// prev_q clears on reset, so an input already high at reset release counts as an edge.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= d;
        end
    end

    assign rise = d & ~prev_q;

endmodule

// File: rtl/led_pulse_stretcher.sv
// Turns short internal events into fixed-length LED blinks separated by a dark gap.
// Events arriving mid-blink are counted and replayed later; overflow raises o_drop.
module led_pulse_stretcher
    import led_pulse_stretcher_pkg::*;
#(
    parameter int ON_CYCLES  = 20,
    parameter int GAP_CYCLES = 20,
    parameter int PEND_MAX   = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic i_event,
    output logic o_led,
    output logic o_busy,
    output logic o_drop
);

    localparam int TW = timer_width(ON_CYCLES, GAP_CYCLES);
    localparam int PW = $clog2(PEND_MAX + 1);

    localparam logic [TW-1:0] ON_LOAD   = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_ONE = TW'(1);
    localparam logic [PW-1:0] PEND_FULL = PW'(PEND_MAX);
    localparam logic [PW-1:0] PEND_ONE  = PW'(1);

    state_t        state;
    state_t        state_next;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_next;
    logic [PW-1:0] pending;
    logic [PW-1:0] pending_next;
    logic          event_hit;
    logic          drop_next;
    logic          gap_done;
    logic          pend_inc;
    logic          pend_dec;

    rise_detect u_rise_detect (
        .clk  (clk),
        .rst  (rst),
        .d    (i_event),
        .rise (event_hit)
    );

    // An event in the last gap cycle with nothing queued starts the next blink directly.
    assign gap_done = (state == GAP) && (timer == '0);
    assign pend_dec = gap_done && (pending != '0);
    assign pend_inc = event_hit &&
                      ((state == ON) ||
                       ((state == GAP) && !(gap_done && (pending == '0))));

    always_comb begin
        state_next   = state;
        timer_next   = timer;
        pending_next = pending;
        drop_next    = 1'b0;

        case (state)
            IDLE: begin
                if (event_hit) begin
                    state_next = ON;
                    timer_next = ON_LOAD;
                end
            end
            ON: begin
                if (timer == '0) begin
                    state_next = GAP;
                    timer_next = GAP_LOAD;
                end else begin
                    timer_next = timer - TIMER_ONE;
                end
            end
            GAP: begin
                if (timer == '0) begin
                    if ((pending != '0) || event_hit) begin
                        state_next = ON;
                        timer_next = ON_LOAD;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    timer_next = timer - TIMER_ONE;
                end
            end
            default: begin
                state_next = IDLE;
                timer_next = '0;
            end
        endcase

        // Simultaneous increment and decrement cancel, even with the queue full.
        if (pend_inc && !pend_dec) begin
            if (pending == PEND_FULL) begin
                drop_next = 1'b1;
            end else begin
                pending_next = pending + PEND_ONE;
            end
        end else if (pend_dec && !pend_inc) begin
            pending_next = pending - PEND_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            timer   <= '0;
            pending <= '0;
            o_led   <= 1'b0;
            o_busy  <= 1'b0;
            o_drop  <= 1'b0;
        end else begin
            state   <= state_next;
            timer   <= timer_next;
            pending <= pending_next;
            o_led   <= (state_next == ON);
            o_busy  <= (state_next != IDLE);
            o_drop  <= drop_next;
        end
    end

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// Scenario bench for led_pulse_stretcher with ON=4, GAP=3, PEND_MAX=2.
// Expected {led,busy,drop} per cycle is queued as stimulus is driven and checked a cycle later.
module tb_led_pulse_stretcher;

    logic clk;
    logic rst;
    logic i_event;
    logic o_led;
    logic o_busy;
    logic o_drop;

    int checks = 0;
    int errors = 0;
    logic [2:0] sb[$];

    led_pulse_stretcher #(
        .ON_CYCLES  (4),
        .GAP_CYCLES (3),
        .PEND_MAX   (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_event (i_event),
        .o_led   (o_led),
        .o_busy  (o_busy),
        .o_drop  (o_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic in_rng(input int c, input int lo, input int hi);
        return (c >= lo) && (c <= hi);
    endfunction

    function automatic logic pulse_at(input int c, input int edges[$]);
        logic hit;
        hit = 1'b0;
        foreach (edges[i]) if (edges[i] == c) hit = 1'b1;
        return hit;
    endfunction

    task automatic test_reset();
        logic [2:0] obs;
        logic [2:0] exp_v;
        for (int c = 0; c <= 6; c++) begin
            if (c > 0) begin
                obs = {o_led, o_busy, o_drop};
                exp_v = sb.pop_front();
                checks++;
                if (obs !== exp_v) begin
                    errors++;
                    $display("[TB] FAIL reset cycle %0d {led,busy,drop} got %b expected %b", c, obs, exp_v);
                end
            end
            if (c < 6) begin
                rst = (c <= 2);
                i_event = 1'b0;
                sb.push_back(3'b000);
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_single();
        logic [2:0] obs;
        logic [2:0] exp_v;
        int edges[$];
        edges = '{10};
        for (int c = 0; c <= 22; c++) begin
            if (c > 0) begin
                obs = {o_led, o_busy, o_drop};
                exp_v = sb.pop_front();
                checks++;
                if (obs !== exp_v) begin
                    errors++;
                    $display("[TB] FAIL single cycle %0d {led,busy,drop} got %b expected %b", c, obs, exp_v);
                end
            end
            if (c < 22) begin
                rst = (c == 0);
                i_event = pulse_at(c, edges);
                sb.push_back({in_rng(c + 1, 11, 14), in_rng(c + 1, 11, 17), 1'b0});
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_queued();
        logic [2:0] obs;
        logic [2:0] exp_v;
        int edges[$];
        edges = '{10, 12, 16};
        for (int c = 0; c <= 36; c++) begin
            if (c > 0) begin
                obs = {o_led, o_busy, o_drop};
                exp_v = sb.pop_front();
                checks++;
                if (obs !== exp_v) begin
                    errors++;
                    $display("[TB] FAIL queued cycle %0d {led,busy,drop} got %b expected %b", c, obs, exp_v);
                end
            end
            if (c < 36) begin
                rst = (c == 0);
                i_event = pulse_at(c, edges);
                sb.push_back({in_rng(c + 1, 11, 14) | in_rng(c + 1, 18, 21) | in_rng(c + 1, 25, 28),
                              in_rng(c + 1, 11, 31), 1'b0});
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_overflow();
        logic [2:0] obs;
        logic [2:0] exp_v;
        int edges[$];
        edges = '{10, 12, 14, 16};
        for (int c = 0; c <= 36; c++) begin
            if (c > 0) begin
                obs = {o_led, o_busy, o_drop};
                exp_v = sb.pop_front();
                checks++;
                if (obs !== exp_v) begin
                    errors++;
                    $display("[TB] FAIL overflow cycle %0d {led,busy,drop} got %b expected %b", c, obs, exp_v);
                end
            end
            if (c < 36) begin
                rst = (c == 0);
                i_event = pulse_at(c, edges);
                sb.push_back({in_rng(c + 1, 11, 14) | in_rng(c + 1, 18, 21) | in_rng(c + 1, 25, 28),
                              in_rng(c + 1, 11, 31), (c + 1 == 17)});
                @(posedge clk); #1;
            end
        end
    endtask

    // Edge in the last gap cycle with an empty queue: exactly two blinks, nothing left queued.
    task automatic test_final_gap_direct();
        logic [2:0] obs;
        logic [2:0] exp_v;
        int edges[$];
        edges = '{10, 17};
        for (int c = 0; c <= 32; c++) begin
            if (c > 0) begin
                obs = {o_led, o_busy, o_drop};
                exp_v = sb.pop_front();
                checks++;
                if (obs !== exp_v) begin
                    errors++;
                    $display("[TB] FAIL final_gap_direct cycle %0d {led,busy,drop} got %b expected %b", c, obs, exp_v);
                end
            end
            if (c < 32) begin
                rst = (c == 0);
                i_event = pulse_at(c, edges);
                sb.push_back({in_rng(c + 1, 11, 14) | in_rng(c + 1, 18, 21),
                              in_rng(c + 1, 11, 24), 1'b0});
                @(posedge clk); #1;
            end
        end
    endtask

    // Queue full (2) and an edge in the last gap cycle: no drop, four blinks in total.
    task automatic test_final_gap_full();
        logic [2:0] obs;
        logic [2:0] exp_v;
        int edges[$];
        edges = '{10, 12, 14, 17};
        for (int c = 0; c <= 44; c++) begin
            if (c > 0) begin
                obs = {o_led, o_busy, o_drop};
                exp_v = sb.pop_front();
                checks++;
                if (obs !== exp_v) begin
                    errors++;
                    $display("[TB] FAIL final_gap_full cycle %0d {led,busy,drop} got %b expected %b", c, obs, exp_v);
                end
            end
            if (c < 44) begin
                rst = (c == 0);
                i_event = pulse_at(c, edges);
                sb.push_back({in_rng(c + 1, 11, 14) | in_rng(c + 1, 18, 21) |
                              in_rng(c + 1, 25, 28) | in_rng(c + 1, 32, 35),
                              in_rng(c + 1, 11, 38), 1'b0});
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_held();
        logic [2:0] obs;
        logic [2:0] exp_v;
        for (int c = 0; c <= 48; c++) begin
            if (c > 0) begin
                obs = {o_led, o_busy, o_drop};
                exp_v = sb.pop_front();
                checks++;
                if (obs !== exp_v) begin
                    errors++;
                    $display("[TB] FAIL held cycle %0d {led,busy,drop} got %b expected %b", c, obs, exp_v);
                end
            end
            if (c < 48) begin
                rst = (c == 0);
                i_event = in_rng(c, 10, 40);
                sb.push_back({in_rng(c + 1, 11, 14), in_rng(c + 1, 11, 17), 1'b0});
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_reset_mid_blink();
        logic [2:0] obs;
        logic [2:0] exp_v;
        int edges[$];
        edges = '{10};
        for (int c = 0; c <= 22; c++) begin
            if (c > 0) begin
                obs = {o_led, o_busy, o_drop};
                exp_v = sb.pop_front();
                checks++;
                if (obs !== exp_v) begin
                    errors++;
                    $display("[TB] FAIL reset_mid_blink cycle %0d {led,busy,drop} got %b expected %b", c, obs, exp_v);
                end
            end
            if (c < 22) begin
                rst = (c == 0) || (c == 12);
                i_event = pulse_at(c, edges);
                sb.push_back({in_rng(c + 1, 11, 12), in_rng(c + 1, 11, 12), 1'b0});
                @(posedge clk); #1;
            end
        end
    endtask

    // Input already high when reset releases at cycle 4 counts as one event.
    task automatic test_reset_held_event();
        logic [2:0] obs;
        logic [2:0] exp_v;
        for (int c = 0; c <= 20; c++) begin
            if (c > 0) begin
                obs = {o_led, o_busy, o_drop};
                exp_v = sb.pop_front();
                checks++;
                if (obs !== exp_v) begin
                    errors++;
                    $display("[TB] FAIL reset_held_event cycle %0d {led,busy,drop} got %b expected %b", c, obs, exp_v);
                end
            end
            if (c < 20) begin
                rst = (c <= 3);
                i_event = 1'b1;
                sb.push_back({in_rng(c + 1, 5, 8), in_rng(c + 1, 5, 11), 1'b0});
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        i_event = 1'b0;
        @(posedge clk); #1;
        $display("[TB] starting led_pulse_stretcher scenarios");
        test_reset();
        test_single();
        test_queued();
        test_overflow();
        test_final_gap_direct();
        test_final_gap_full();
        test_held();
        test_reset_mid_blink();
        test_reset_held_event();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
